usb_cdr_os: RTL and testbench



---
 rtl/usb_cdr_os.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_usb_cdr_os.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cdr_os.sv
//------------------------------------------------------------------------------
// usb_cdr_os
//
// Oversampled Hogge-style clock/data recovery for the USB receive path.
// It runs from a single 48 MHz clock and handles low speed (1.5 Mb/s) and
// full speed (12 Mb/s), selected at run time. It retimes D+/D- onto a
// recovered bit phase, emits one strobe per bit, provides a synchronised
// copy of the raw line state and reports when the recovered phase is stable.
//
// Optional feature macro:
//   USB_CDR_GLITCH_FILTER_EN - when defined, the data path sees a bitwise
//   3-tap majority of the last three samples of d. This rejects
//   single-cycle glitches and adds two cycles of latency to q. When it is
//   not defined, the data path uses d directly and has no filter registers.
//
// Parameters:
//   OSR_LS    - clocks per bit in low speed (multiple of 4, >= 4)
//   OSR_FS    - clocks per bit in full speed (multiple of 4, >= 4)
//   LOCK_BITS - consecutive in-tolerance bit periods needed for locked
//   LOCK_TOL  - largest |dphase| at the adjust point counted as in-tolerance
//
// Ports:
//   clk        in   system clock, 48 MHz
//   reset_n    in   asynchronous active-low reset
//   fs         in   speed select: 1 = full speed, 0 = low speed
//   d          in   raw {D-, D+} from the PHY (bit 0 = D+)
//   q          out  retimed data, valid while strobe is high
//   line_state out  two-flop-synchronised raw {D-, D+}
//   strobe     out  one-cycle pulse per recovered bit
//   locked     out  recovered phase is stable
//------------------------------------------------------------------------------

// Line pair as seen by the PHY: bit 1 = D-, bit 0 = D+.
typedef logic [1:0] d_port_t;

module usb_cdr_os #(
    parameter int OSR_LS    = 32,
    parameter int OSR_FS    = 4,
    parameter int LOCK_BITS = 8,
    parameter int LOCK_TOL  = 1
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    fs,
    input  d_port_t d,
    output d_port_t q,
    output d_port_t line_state,
    output logic    strobe,
    output logic    locked
);

    // Idle J state (D+ high, D- low).
    localparam d_port_t LINE_J = 2'b01;

    // Phase counter sizing. The extended width holds phase + 2 before the
    // modulo-N wrap and every sampling point for either speed.
    localparam int OSR_MAX = (OSR_LS > OSR_FS) ? OSR_LS : OSR_FS;
    localparam int PH_W    = $clog2(OSR_MAX);
    localparam int PX_W    = PH_W + 1;

    localparam logic [PX_W-1:0] N_LS   = PX_W'(OSR_LS);
    localparam logic [PX_W-1:0] N_FS   = PX_W'(OSR_FS);
    localparam logic [PX_W-1:0] PX_ONE = PX_W'(1);
    localparam logic [PX_W-1:0] PX_TWO = PX_W'(2);

    // Phase error accumulator: signed, saturating.
    localparam int DP_W = $clog2(OSR_LS) + 2;

    localparam logic signed [DP_W-1:0] DP_MAX  = {1'b0, {(DP_W-1){1'b1}}};
    localparam logic signed [DP_W-1:0] DP_MIN  = {1'b1, {(DP_W-1){1'b0}}};
    localparam logic signed [DP_W-1:0] DP_ZERO = '0;
    localparam logic signed [DP_W-1:0] DP_ONE  = DP_W'(1);
    localparam logic        [DP_W-1:0] DP_TOL  = DP_W'(LOCK_TOL);

    // Lock counter saturates at LOCK_BITS.
    localparam int LC_W = $clog2(LOCK_BITS + 1);

    localparam logic [LC_W-1:0] LOCK_MAX = LC_W'(LOCK_BITS);
    localparam logic [LC_W-1:0] LC_ONE   = LC_W'(1);

    //--------------------------------------------------------------------------
    // Arithmetic helpers
    //--------------------------------------------------------------------------

    // Saturating +1 on the phase error.
    function automatic logic signed [DP_W-1:0] sat_inc(
        input logic signed [DP_W-1:0] v
    );
        if (v == DP_MAX) begin
            return v;
        end
        return v + DP_ONE;
    endfunction

    // Saturating -1 on the phase error.
    function automatic logic signed [DP_W-1:0] sat_dec(
        input logic signed [DP_W-1:0] v
    );
        if (v == DP_MIN) begin
            return v;
        end
        return v - DP_ONE;
    endfunction

    // Magnitude of the phase error. Returned unsigned so that the most
    // negative value maps onto 2^(DP_W-1) instead of wrapping.
    function automatic logic [DP_W-1:0] dp_mag(
        input logic signed [DP_W-1:0] v
    );
        logic [DP_W-1:0] m;
        m = (v < DP_ZERO) ? -v : v;
        return m;
    endfunction

    // Modulo-N reduction for a phase that has gone at most N past the end.
    function automatic logic [PH_W-1:0] wrap_phase(
        input logic [PX_W-1:0] v,
        input logic [PX_W-1:0] n
    );
        logic [PX_W-1:0] r;
        r = (v >= n) ? (v - n) : v;
        return r[PH_W-1:0];
    endfunction

    // Bitwise 2-of-3 majority vote.
    function automatic d_port_t majority3(
        input d_port_t a,
        input d_port_t b,
        input d_port_t c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    logic                   fs_q;
    logic [PH_W-1:0]        phase;
    logic signed [DP_W-1:0] dphase;
    logic [LC_W-1:0]        lock_cnt;
    d_port_t                d_shift1;
    d_port_t                d_shift2;
    d_port_t                line_sync_p0;
    d_port_t                line_sync_p1;

    // Data seen by the phase detector and the sampling flops.
    d_port_t                di;

    //--------------------------------------------------------------------------
    // Optional glitch filter on the data path
    //--------------------------------------------------------------------------
`ifdef USB_CDR_GLITCH_FILTER_EN
    d_port_t filt_p0;
    d_port_t filt_p1;
    d_port_t filt_p2;

    // filter stage boundary: three-deep history of d
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_p0 <= LINE_J;
            filt_p1 <= LINE_J;
            filt_p2 <= LINE_J;
        end else begin
            filt_p0 <= d;
            filt_p1 <= filt_p0;
            filt_p2 <= filt_p1;
        end
    end

    // An edge needs two of the three samples before it reaches di, so a
    // single-cycle pulse never gets through.
    assign di = majority3(filt_p0, filt_p1, filt_p2);
`else
    assign di = d;
`endif

    //--------------------------------------------------------------------------
    // Sampling points for the current speed
    //--------------------------------------------------------------------------
    logic [PX_W-1:0] n_cur;
    logic [PX_W-1:0] s1_pt;
    logic [PX_W-1:0] s2_pt;
    logic [PX_W-1:0] adj_pt;
    logic [PX_W-1:0] ph_ext;
    logic [PH_W-1:0] ph_inc1;
    logic [PH_W-1:0] ph_inc2;

    always_comb begin
        n_cur   = fs ? N_FS : N_LS;
        s1_pt   = n_cur >> 2;
        s2_pt   = s1_pt + (s1_pt << 1);
        // The adjust point follows S2 and wraps to 0 when S2 is the last phase.
        adj_pt  = ((s2_pt + PX_ONE) == n_cur) ? '0 : (s2_pt + PX_ONE);
        ph_ext  = {1'b0, phase};
        ph_inc1 = wrap_phase(ph_ext + PX_ONE, n_cur);
        ph_inc2 = wrap_phase(ph_ext + PX_TWO, n_cur);
    end

    logic at_s1;
    logic at_s2;
    logic at_adj;
    logic fs_chg;

    assign at_s1  = (ph_ext == s1_pt);
    assign at_s2  = (ph_ext == s2_pt);
    assign at_adj = (ph_ext == adj_pt);
    assign fs_chg = fs ^ fs_q;

    //--------------------------------------------------------------------------
    // Hogge phase detector on D+ only
    //--------------------------------------------------------------------------
    // down: the centre sample differs from the previous retimed bit, i.e.
    // the sampling phase sits late in the bit. up: live data already differs
    // from the centre sample, i.e. the phase sits early. Down wins a tie.
    logic down;
    logic up;

    assign down = (d_shift1[0] != d_shift2[0]);
    assign up   = (di[0] != d_shift1[0]);

    // Lock bookkeeping for the adjust point.
    logic            in_tol;
    logic [LC_W-1:0] lc_next;

    assign in_tol  = (dp_mag(dphase) <= DP_TOL);
    assign lc_next = (lock_cnt == LOCK_MAX) ? lock_cnt : (lock_cnt + LC_ONE);

    //--------------------------------------------------------------------------
    // Recovery core
    //--------------------------------------------------------------------------
    // core stage boundary: phase, phase error, lock and retimed data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fs_q     <= 1'b0;
            phase    <= '0;
            dphase   <= '0;
            lock_cnt <= '0;
            locked   <= 1'b0;
            strobe   <= 1'b0;
            d_shift1 <= LINE_J;
            d_shift2 <= LINE_J;
        end else begin
            fs_q <= fs;
            if (fs_chg) begin
                // Speed change: restart the bit phase and lock acquisition.
                // The retimed data is kept so q does not glitch.
                phase    <= '0;
                dphase   <= '0;
                lock_cnt <= '0;
                locked   <= 1'b0;
                strobe   <= 1'b0;
            end else begin
                strobe <= at_s2;
                if (at_s1) begin
                    d_shift1 <= di;
                end
                if (at_s2) begin
                    d_shift2 <= d_shift1;
                end
                if (at_adj) begin
                    // This cycle's up/down are discarded; the accumulated
                    // error decides the step and the lock count.
                    dphase <= '0;
                    if (in_tol) begin
                        lock_cnt <= lc_next;
                        locked   <= (lc_next == LOCK_MAX);
                    end else begin
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                    end
                    if (dphase > DP_ZERO) begin
                        phase <= ph_inc2;
                    end else if (dphase < DP_ZERO) begin
                        // Holding keeps phase on ADJ, so the next cycle is
                        // another adjust point with a cleared error and
                        // steps by one.
                        phase <= phase;
                    end else begin
                        phase <= ph_inc1;
                    end
                end else begin
                    phase <= ph_inc1;
                    if (down) begin
                        dphase <= sat_dec(dphase);
                    end else if (up) begin
                        dphase <= sat_inc(dphase);
                    end
                end
            end
        end
    end

    assign q = d_shift2;

    //--------------------------------------------------------------------------
    // Line-state synchroniser on raw d
    //--------------------------------------------------------------------------
    // sync stage boundary: two flops, independent of filter and phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_sync_p0 <= LINE_J;
            line_sync_p1 <= LINE_J;
        end else begin
            line_sync_p0 <= d;
            line_sync_p1 <= line_sync_p0;
        end
    end

    assign line_state = line_sync_p1;

endmodule

// File: tb/tb_usb_cdr_os.sv
//------------------------------------------------------------------------------
// tb_usb_cdr_os
//
// Self-checking bench for usb_cdr_os. Random and directed line activity is
// driven into the DUT while a cycle-level reference model, built from the
// recovery rules with plain integer arithmetic, predicts every output.
// Honours USB_CDR_GLITCH_FILTER_EN the same way as the design.
//------------------------------------------------------------------------------
module tb_usb_cdr_os;

    localparam int OSR_LS    = 32;
    localparam int OSR_FS    = 4;
    localparam int LOCK_BITS = 8;
    localparam int LOCK_TOL  = 1;
    localparam int DPW       = $clog2(OSR_LS) + 2;
    localparam int DP_MAX    = (1 << (DPW - 1)) - 1;
    localparam int DP_MIN    = -(1 << (DPW - 1));

    localparam logic [1:0] J   = 2'b01;
    localparam logic [1:0] K   = 2'b10;
    localparam logic [1:0] SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       fs;
    logic [1:0] d;
    logic [1:0] q;
    logic [1:0] line_state;
    logic       strobe;
    logic       locked;

    always #5 clk = ~clk;

    usb_cdr_os #(
        .OSR_LS    (OSR_LS),
        .OSR_FS    (OSR_FS),
        .LOCK_BITS (LOCK_BITS),
        .LOCK_TOL  (LOCK_TOL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fs         (fs),
        .d          (d),
        .q          (q),
        .line_state (line_state),
        .strobe     (strobe),
        .locked     (locked)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    int         m_phase;
    int         m_err;
    int         m_good;
    logic       m_locked;
    logic       m_strobe;
    logic       m_fsq;
    logic [1:0] m_mid;
    logic [1:0] m_out;
    logic [1:0] m_sy1;
    logic [1:0] m_ls;
`ifdef USB_CDR_GLITCH_FILTER_EN
    logic [1:0] m_hist [3];
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > DP_MAX) return DP_MAX;
        if (v < DP_MIN) return DP_MIN;
        return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_err    = 0;
        m_good   = 0;
        m_locked = 1'b0;
        m_strobe = 1'b0;
        m_fsq    = 1'b0;
        m_mid    = J;
        m_out    = J;
        m_sy1    = J;
        m_ls     = J;
`ifdef USB_CDR_GLITCH_FILTER_EN
        for (int i = 0; i < 3; i++) m_hist[i] = J;
`endif
    endtask

    // One clock edge of the recovery rules, using the inputs currently driven.
    task automatic model_step();
        int         n;
        int         s1;
        int         s2;
        int         adj;
        int         vote;
        logic [1:0] di;
`ifdef USB_CDR_GLITCH_FILTER_EN
        di = (m_hist[0] & m_hist[1]) | (m_hist[0] & m_hist[2]) | (m_hist[1] & m_hist[2]);
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = d;
`else
        di = d;
`endif
        m_ls  = m_sy1;
        m_sy1 = d;
        n   = fs ? OSR_FS : OSR_LS;
        s1  = n / 4;
        s2  = 3 * n / 4;
        adj = (s2 + 1) % n;
        if (fs != m_fsq) begin
            m_phase  = 0;
            m_err    = 0;
            m_good   = 0;
            m_locked = 1'b0;
            m_strobe = 1'b0;
        end else begin
            if (m_mid[0] != m_out[0])  vote = -1;
            else if (di[0] != m_mid[0]) vote = 1;
            else                        vote = 0;
            m_strobe = (m_phase == s2);
            if (m_phase == s2) m_out = m_mid;
            if (m_phase == s1) m_mid = di;
            if (m_phase == adj) begin
                if (iabs(m_err) <= LOCK_TOL) m_good = (m_good < LOCK_BITS) ? m_good + 1 : LOCK_BITS;
                else                         m_good = 0;
                m_locked = (m_good == LOCK_BITS);
                if (m_err > 0)      m_phase = (m_phase + 2) % n;
                else if (m_err == 0) m_phase = (m_phase + 1) % n;
                m_err = 0;
            end else begin
                m_err   = clamp(m_err + vote);
                m_phase = (m_phase + 1) % n;
            end
        end
        m_fsq = fs;
    endtask

    // Advance one clock and compare all outputs one time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("q", q, m_out);
        check("line_state", line_state, m_ls);
        check("strobe", strobe, m_strobe);
        check("locked", locked, m_locked);
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic apply_reset(input int cycles);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_q", q, J);
        check("rst_line_state", line_state, J);
        check("rst_strobe", strobe, 1'b0);
        check("rst_locked", locked, 1'b0);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            model_reset();
        end
        reset_n = 1'b1;
    endtask

    function automatic logic [1:0] pick_sym(input int mode, input logic [1:0] cur);
        if (mode == 3) return (cur == J) ? K : J;
        if ($urandom_range(15) == 0) return SE0;
        return ($urandom_range(1) != 0) ? K : J;
    endfunction

    // Drive a bit stream of nominal length 'period'. mode 0: clean,
    // 1: +/-1 clock jitter, 2: periodic 2-clock phase jumps, 3: alternating J/K.
    // Strobe spacing is checked against N-1..N+1.
    task automatic run_stream(input int cycles, input int period, input int mode);
        int timer;
        int bits;
        int last;
        int n;
        timer = 3;
        bits  = 0;
        last  = -1;
        n     = fs ? OSR_FS : OSR_LS;
        for (int i = 0; i < cycles; i++) begin
            if (timer == 0) begin
                d     = pick_sym(mode, d);
                bits++;
                timer = period;
                if (mode == 1) timer += int'($urandom_range(2)) - 1;
                if (mode == 2 && bits % 12 == 0) timer += 2;
                if (mode == 2 && bits % 12 == 6) timer -= 2;
            end
            timer--;
            cycle();
            if (strobe) begin
                if (last >= 0) check("strobe_spacing", ((i - last) >= n - 1) && ((i - last) <= n + 1), 1'b1);
                last = i;
            end
        end
    endtask

    task automatic idle_cycles(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            cycle();
`ifdef USB_CDR_GLITCH_FILTER_EN
            check("glitch_q", q, J);
`endif
        end
    endtask

    initial begin
        int nstb;
        int last;
        reset_n = 1'b1;
        fs      = 1'b0;
        d       = J;
        model_reset();
        #1;
        apply_reset(3);

        // J idle at low speed: fixed strobe spacing, q = J, lock after 8 bits.
        nstb = 0;
        last = -1;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (strobe) begin
                nstb++;
                if (last < 0) check("first_strobe", i, 3 * OSR_LS / 4);
                else          check("idle_period", i - last, OSR_LS);
                last = i;
                check("idle_q", q, J);
                if (nstb == LOCK_BITS) check("lock_before", locked, 1'b0);
            end
            if (nstb == LOCK_BITS && last == i - 1) check("lock_after", locked, 1'b1);
        end

        // Low-speed random data, late edges and jitter.
        run_stream(2500, OSR_LS, 1);
        // Periodic 2-clock phase jumps.
        run_stream(2500, OSR_LS, 2);

        // Full speed alternating J/K with speed toggles mid-stream.
        fs = 1'b1;
        cycle();
        check("fs_chg_locked", locked, 1'b0);
        check("fs_chg_strobe", strobe, 1'b0);
        run_stream(400, OSR_FS, 3);
        fs = 1'b0;
        cycle();
        check("fs_drop_locked", locked, 1'b0);
        fs = 1'b1;
        cycle();
        check("fs_back_locked", locked, 1'b0);
        run_stream(400, OSR_FS, 3);
        run_stream(400, OSR_FS, 1);

        // Back to low speed, single-cycle K glitches on J idle.
        fs = 1'b0;
        d  = J;
        cycle();
        for (int i = 0; i < 80; i++) cycle();
        for (int g = 0; g < 12; g++) begin
            idle_cycles(int'($urandom_range(40, 5)));
            d = K;
            cycle();
            d = J;
        end
        idle_cycles(40);

        // Reset in the middle of a packet.
        run_stream(500, OSR_LS, 1);
        d = K;
        apply_reset(2);
        run_stream(600, OSR_LS, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
